seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Time-multiplexed 7-segment scan driver, parametrised in digit count, scan rate, output polarity and brightness resolution.
- Generalises the fixed 4-digit display top to N digits.
- Adds hex decode, per-digit decimal point and blanking, leading-zero suppression, PWM brightness, anti-ghost blanking and tear-free frame-synchronous update.
- Sits between the board-level display pins and any value producer (counters, UART, debug registers).

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
CLK_DIV, 50000, CLK cycles per digit slot (>=4)
BRIGHT_W, 4, brightness control width
SEG_ACT_LOW, 1, 1 = segment outputs active-low
DIG_ACT_LOW, 1, 1 = digit enables active-low

Ports:
CLK  in  1  system clock
CLR  in  1  asynchronous active-high reset
DATA  in  4*NUM_DIGITS  hex nibbles; digit 0 = DATA[3:0] (rightmost)
DP  in  NUM_DIGITS  decimal point per digit
BLANK  in  NUM_DIGITS  force digit dark
LZ_EN  in  1  leading-zero suppression enable
BRIGHT  in  BRIGHT_W  brightness, 0 = dark, all-ones = full
LOAD  in  1  capture DATA/DP/BLANK into pending register
SEG  out  7  segments, SEG[0]=a .. SEG[6]=g
SEG_DP  out  1  decimal point segment
DIG  out  NUM_DIGITS  digit enables, one-hot when active
FRAME  out  1  1-cycle pulse at each frame boundary

Behaviour:
- One clock (CLK); CLR asynchronous, active-high. All state resets immediately on CLR=1.
- CLR reset values:
  - prescaler, scan index, PWM counter: 0.
  - pending and display registers: 0; pend_valid: 0.
  - SEG/SEG_DP: inactive level. DIG: all inactive. FRAME: 0.
- Prescaler counts 0..CLK_DIV-1 and wraps. At terminal count, the scan index advances mod NUM_DIGITS.
- Frame boundary: the cycle in which the index wraps NUM_DIGITS-1 -> 0. On that cycle:
  - FRAME=1.
  - If pend_valid, the pending register is copied into the display register and pend_valid clears.
- LOAD=1 captures the inputs into the pending register and sets pend_valid. The display never changes mid-frame.
- LOAD on a frame-boundary cycle bypasses: the new inputs go straight to the display register and pend_valid=0.
- Multiple LOADs within one frame: the last one wins.
- PWM counter: free-running BRIGHT_W bits, increments every cycle.
  - on = (BRIGHT == all-ones) OR (pwm_cnt < BRIGHT).
  - BRIGHT=0 means always dark.
- Anti-ghost: all digits are forced inactive while prescaler == 0 in each slot.
- Digit i is lit when all of the following hold:
  - i == index;
  - on;
  - prescaler != 0;
  - BLANK[i] == 0;
  - the digit is not LZ-suppressed.
- LZ suppression (LZ_EN=1): digit k>0 is suppressed if its nibble is 0 and every digit above it is 0. Digit 0 is never suppressed. DP is suppressed with its digit.
- Hex decode, active-high pattern {g..a}: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Polarity: SEG_ACT_LOW inverts SEG and SEG_DP. DIG_ACT_LOW inverts DIG.
- When no digit is lit, SEG/SEG_DP are driven inactive.
- Outputs are registered: SEG/SEG_DP/DIG reflect the prescaler/index/PWM state of the previous cycle (1-cycle latency).
- CLR mid-frame: the display goes dark next edge-independent. Scanning restarts at digit 0; the pending update is lost.
- Width rules: prescaler width = clog2(CLK_DIV); index width = clog2(NUM_DIGITS), minimum 1.

Test Plan:
- Reset:
  - Stimulus: CLR=1 for 3 cycles, default polarity.
  - Expect DIG=4'b1111, SEG=7'h7F, SEG_DP=1, FRAME=0.
  - After release, first active DIG=4'b1110 appears at cycle 2 of slot 0.
- Scan/decode:
  - Stimulus: CLK_DIV=8, BRIGHT=4'hF, LOAD DATA=16'h12AF.
  - After the next FRAME, slots show in order ~71(F), ~77(A), ~5B(2), ~06(1).
  - Each digit is dark on prescaler 0 (7 lit cycles per 8). FRAME period = 32 cycles.
- Tear-free update:
  - Stimulus: LOAD 16'h1111 then 16'h2222 mid-frame.
  - Current frame keeps the old value; next frame shows 2 on all digits, never 1.
  - LOAD on a FRAME cycle takes effect in that same frame.
- Leading zeros:
  - Stimulus: DATA=16'h0050, LZ_EN=1.
  - Digits 3 and 2 stay dark; digit 1 shows 5; digit 0 shows 0.
  - DATA=16'h0000 shows only digit 0 = 0. With LZ_EN=0, all four digits are lit.
- Brightness:
  - BRIGHT=0: DIG never active over 2 frames.
  - BRIGHT=4: active 4 of every 16 cycles (excluding prescaler 0).
  - BRIGHT=15: always on.
- Blank/DP and reset mid-frame:
  - Stimulus: BLANK=4'b0100, DP=4'b0001.
  - Digit 2 stays dark; SEG_DP=0 only in the digit 0 slot.
  - CLR pulse mid-frame: outputs go inactive immediately; scanning resumes at digit 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - N-digit time-multiplexed 7-segment scan driver
module seg7_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int CLK_DIV     = 50000,
   parameter int BRIGHT_W    = 4,
   parameter bit SEG_ACT_LOW = 1'b1,
   parameter bit DIG_ACT_LOW = 1'b1
) (
   input  logic                      CLK,
   input  logic                      CLR,
   input  logic [4*NUM_DIGITS-1:0]   DATA,
   input  logic [NUM_DIGITS-1:0]     DP,
   input  logic [NUM_DIGITS-1:0]     BLANK,
   input  logic                      LZ_EN,
   input  logic [BRIGHT_W-1:0]       BRIGHT,
   input  logic                      LOAD,
   output logic [6:0]                SEG,
   output logic                      SEG_DP,
   output logic [NUM_DIGITS-1:0]     DIG,
   output logic                      FRAME
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0]         PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF    = {7{SEG_ACT_LOW}};
   localparam logic                  SEG_DP_OFF = SEG_ACT_LOW;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACT_LOW}};

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic [BRIGHT_W-1:0]     pwm_cnt;

   logic [4*NUM_DIGITS-1:0] pend_data;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic [NUM_DIGITS-1:0]   pend_blank;
   logic                    pend_valid;

   logic [4*NUM_DIGITS-1:0] disp_data;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic [NUM_DIGITS-1:0]   disp_blank;

   logic                    slot_end;
   logic                    frame_tick;
   logic                    pwm_on;
   logic [NUM_DIGITS-1:0]   lz_sup;
   logic                    all_zero;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic                    cur_sup;
   logic                    lit;
   logic [6:0]              seg_n;
   logic                    seg_dp_n;
   logic [NUM_DIGITS-1:0]   dig_n;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0:    hex_to_seg = 7'h3F;
         4'h1:    hex_to_seg = 7'h06;
         4'h2:    hex_to_seg = 7'h5B;
         4'h3:    hex_to_seg = 7'h4F;
         4'h4:    hex_to_seg = 7'h66;
         4'h5:    hex_to_seg = 7'h6D;
         4'h6:    hex_to_seg = 7'h7D;
         4'h7:    hex_to_seg = 7'h07;
         4'h8:    hex_to_seg = 7'h7F;
         4'h9:    hex_to_seg = 7'h6F;
         4'hA:    hex_to_seg = 7'h77;
         4'hB:    hex_to_seg = 7'h7C;
         4'hC:    hex_to_seg = 7'h39;
         4'hD:    hex_to_seg = 7'h5E;
         4'hE:    hex_to_seg = 7'h79;
         default: hex_to_seg = 7'h71;
      endcase
   endfunction

   assign slot_end   = (presc == PRESC_LAST);
   assign frame_tick = slot_end && (idx == IDX_LAST);
   assign FRAME      = frame_tick;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         presc <= '0;
         idx   <= '0;
      end else if (slot_end) begin
         presc <= '0;
         idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
         presc <= presc + PW'(1);
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
      end
   end

   // Display register only moves at the frame boundary; a LOAD on that very
   // cycle wins over an older pending value and leaves nothing pending.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_valid <= 1'b0;
         disp_data  <= '0;
         disp_dp    <= '0;
         disp_blank <= '0;
      end else begin
         if (LOAD && !frame_tick) begin
            pend_data  <= DATA;
            pend_dp    <= DP;
            pend_blank <= BLANK;
            pend_valid <= 1'b1;
         end
         if (frame_tick) begin
            if (LOAD) begin
               disp_data  <= DATA;
               disp_dp    <= DP;
               disp_blank <= BLANK;
            end else if (pend_valid) begin
               disp_data  <= pend_data;
               disp_dp    <= pend_dp;
               disp_blank <= pend_blank;
            end
            pend_valid <= 1'b0;
         end
      end
   end

   assign pwm_on = (&BRIGHT) || (pwm_cnt < BRIGHT);

   // Walk down from the top digit; suppression stops at the first non-zero nibble.
   always_comb begin
      lz_sup   = '0;
      all_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         all_zero  = all_zero && (disp_data[4*k +: 4] == 4'h0);
         lz_sup[k] = LZ_EN && all_zero;
      end
   end

   always_comb begin
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cur_sup   = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_nib   = disp_data[4*i +: 4];
            cur_dp    = disp_dp[i];
            cur_blank = disp_blank[i];
            cur_sup   = lz_sup[i];
         end
      end
   end

   // Prescaler 0 of every slot is dead time so the previous digit cannot ghost.
   assign lit = pwm_on && (presc != '0) && !cur_blank && !cur_sup;

   always_comb begin
      seg_n    = lit ? hex_to_seg(cur_nib) : 7'h00;
      seg_dp_n = lit && cur_dp;
      dig_n    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         dig_n[i] = lit && (idx == IW'(i));
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         SEG    <= SEG_OFF;
         SEG_DP <= SEG_DP_OFF;
         DIG    <= DIG_OFF;
      end else begin
         SEG    <= seg_n ^ SEG_OFF;
         SEG_DP <= seg_dp_n ^ SEG_DP_OFF;
         DIG    <= dig_n ^ DIG_OFF;
      end
   end

endmodule
